// File: rtl/writeback_stage.sv
// MEM/WB pipeline stage: registers the completing instruction, extracts load data,
// drives the register-file write port, forwarding info, retire counter and load-error flags.
module writeback_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RF_AW  = 5,
    parameter int unsigned WREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [RF_AW-1:0]  in_rd,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_load_word,
    output logic [WREG_W-1:0] write_reg,
    output logic [XLEN-1:0]   write_data,
    output logic              regwrite,
    output logic              fwd_valid,
    output logic [RF_AW-1:0]  fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic              load_err,
    output logic              load_err_sticky,
    output logic [31:0]       retire_count
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic              accept;
    logic              misaligned;
    logic              illegal;
    logic              error;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   result;

    logic [WREG_W-1:0] write_reg_d,       write_reg_q;
    logic [XLEN-1:0]   write_data_d,      write_data_q;
    logic              regwrite_d,        regwrite_q;
    logic              load_err_d,        load_err_q;
    logic              load_err_sticky_d, load_err_sticky_q;
    logic [31:0]       retire_count_d,    retire_count_q;

    // Load extraction and alignment/legality classification
    always_comb begin
        shifted    = in_load_word >> {in_addr_lo, 3'b000};
        load_data  = in_load_word;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (in_funct3)
            F3_LB:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH: begin
                load_data  = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                misaligned = in_addr_lo[0];
            end
            F3_LHU: begin
                load_data  = {{(XLEN-16){1'b0}}, shifted[15:0]};
                misaligned = in_addr_lo[0];
            end
            F3_LW: begin
                load_data  = in_load_word;
                misaligned = |in_addr_lo;
            end
            default: illegal = 1'b1;
        endcase
    end

    // ALU writebacks never raise an error regardless of funct3/addr_lo
    always_comb begin
        accept = in_valid & ~flush;
        error  = in_memtoreg & (misaligned | illegal);
        result = in_memtoreg ? load_data : in_alu_result;
    end

    always_comb begin
        write_reg_d       = write_reg_q;
        write_data_d      = write_data_q;
        regwrite_d        = 1'b0;
        load_err_d        = 1'b0;
        load_err_sticky_d = load_err_sticky_q;
        retire_count_d    = retire_count_q;
        if (accept) begin
            write_reg_d                = '0;
            write_reg_d[RF_AW-1:0]     = in_rd;
            write_data_d               = result;
            regwrite_d                 = in_regwrite & (|in_rd) & ~error;
            load_err_d                 = error;
            if (error) begin
                load_err_sticky_d = 1'b1;
            end else begin
                retire_count_d = retire_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg_q       <= '0;
            write_data_q      <= '0;
            regwrite_q        <= 1'b0;
            load_err_q        <= 1'b0;
            load_err_sticky_q <= 1'b0;
            retire_count_q    <= '0;
        end else begin
            write_reg_q       <= write_reg_d;
            write_data_q      <= write_data_d;
            regwrite_q        <= regwrite_d;
            load_err_q        <= load_err_d;
            load_err_sticky_q <= load_err_sticky_d;
            retire_count_q    <= retire_count_d;
        end
    end

    assign write_reg       = write_reg_q;
    assign write_data      = write_data_q;
    assign regwrite        = regwrite_q;
    assign fwd_valid       = regwrite_q;
    assign fwd_rd          = write_reg_q[RF_AW-1:0];
    assign fwd_data        = write_data_q;
    assign load_err        = load_err_q;
    assign load_err_sticky = load_err_sticky_q;
    assign retire_count    = retire_count_q;

endmodule
